// File: rtl/matrix_mem_responder_pkg.sv
// Shared sizing for the matrix storage responder: default element/address widths and array depth.
package matrix_mem_responder_pkg;

    localparam int ELEMENT_WIDTH_DEF   = 16;
    localparam int BRAM_ADDR_WIDTH_DEF = 12;

    function automatic int mem_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    localparam int MEM_DEPTH_DEF = mem_depth(BRAM_ADDR_WIDTH_DEF);

endpackage

// File: rtl/matrix_mem_responder_bram_sdp.sv
// Inferred simple-dual-port storage array: one synchronous read port, one synchronous write port.
module matrix_bram_sdp
    import matrix_mem_responder_pkg::*;
#(
    parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
    parameter int ADDR_WIDTH    = BRAM_ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic [ELEMENT_WIDTH-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_WIDTH-1:0]    wr_addr,
    input  logic [ELEMENT_WIDTH-1:0] wr_data
);

    localparam int DEPTH = mem_depth(ADDR_WIDTH);

    logic [ELEMENT_WIDTH-1:0] mem [0:DEPTH-1];

    // Read samples the array before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/matrix_mem_responder.sv
// Memory-side responder: op port, lower-priority host port, zero-fill sweep.
// Optional macro MATRIX_MEM_RD_BYPASS_EN forwards same-cycle write data to reads.
module matrix_mem_responder
    import matrix_mem_responder_pkg::*;
#(
    parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
    parameter int ADDR_WIDTH    = BRAM_ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_rd_en,
    input  logic [ADDR_WIDTH-1:0]    op_rd_addr,
    output logic [ELEMENT_WIDTH-1:0] op_rd_data,
    input  logic                     op_wr_en,
    input  logic [ADDR_WIDTH-1:0]    op_wr_addr,
    input  logic [ELEMENT_WIDTH-1:0] op_wr_data,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [ADDR_WIDTH-1:0]    host_addr,
    input  logic [ELEMENT_WIDTH-1:0] host_wdata,
    output logic                     host_gnt,
    output logic                     host_rvalid,
    output logic [ELEMENT_WIDTH-1:0] host_rdata,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic                     clr_done
);

    typedef enum logic [1:0] {C_IDLE = 2'd0, C_SWEEP = 2'd1, C_DONE = 2'd2} clr_state_t;

    clr_state_t               state;
    logic [ADDR_WIDTH:0]      sweep_cnt;
    logic [ADDR_WIDTH:0]      sweep_next;
    logic                     clr_start_prev;
    logic                     host_rd_gnt;
    logic                     host_wr_gnt;
    logic                     sweep_wr;
    logic                     mem_rd_en;
    logic [ADDR_WIDTH-1:0]    mem_rd_addr;
    logic [ELEMENT_WIDTH-1:0] mem_rd_q;
    logic                     mem_wr_en;
    logic [ADDR_WIDTH-1:0]    mem_wr_addr;
    logic [ELEMENT_WIDTH-1:0] mem_wr_data;
    logic                     op_vld_p1;
    logic                     host_vld_p1;
    logic [ELEMENT_WIDTH-1:0] op_hold;
    logic [ELEMENT_WIDTH-1:0] host_hold;
    logic [ELEMENT_WIDTH-1:0] rd_word;

    assign host_rd_gnt = host_req & ~host_we & ~op_rd_en;
    assign host_wr_gnt = host_req &  host_we & ~op_wr_en & ~clr_busy;
    assign host_gnt    = host_rd_gnt | host_wr_gnt;
    assign sweep_wr    = clr_busy & ~op_wr_en;
    assign sweep_next  = sweep_cnt + 1'b1;

    assign mem_rd_en   = op_rd_en | host_rd_gnt;
    assign mem_rd_addr = op_rd_en ? op_rd_addr : host_addr;

    always_comb begin
        mem_wr_en   = op_wr_en | sweep_wr | host_wr_gnt;
        mem_wr_addr = host_addr;
        mem_wr_data = host_wdata;
        if (op_wr_en) begin
            mem_wr_addr = op_wr_addr;
            mem_wr_data = op_wr_data;
        end else if (sweep_wr) begin
            mem_wr_addr = sweep_cnt[ADDR_WIDTH-1:0];
            mem_wr_data = '0;
        end
    end

    matrix_bram_sdp #(
        .ELEMENT_WIDTH (ELEMENT_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_bram (
        .clk     (clk),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_q),
        .wr_en   (mem_wr_en),
        .wr_addr (mem_wr_addr),
        .wr_data (mem_wr_data)
    );

`ifdef MATRIX_MEM_RD_BYPASS_EN
    logic                     fwd_hit_p1;
    logic [ELEMENT_WIDTH-1:0] fwd_data_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fwd_hit_p1 <= 1'b0;
        else        fwd_hit_p1 <= mem_rd_en & mem_wr_en & (mem_rd_addr == mem_wr_addr);
    end

    always_ff @(posedge clk) begin
        if (mem_wr_en) fwd_data_p1 <= mem_wr_data;
    end

    assign rd_word = fwd_hit_p1 ? fwd_data_p1 : mem_rd_q;
`else
    assign rd_word = mem_rd_q;
`endif

    // ---- stage p1: the array word appears; each requester keeps its last word in a hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vld_p1   <= 1'b0;
            host_vld_p1 <= 1'b0;
            op_hold     <= '0;
            host_hold   <= '0;
        end else begin
            op_vld_p1   <= op_rd_en;
            host_vld_p1 <= host_rd_gnt;
            if (op_vld_p1)   op_hold   <= rd_word;
            if (host_vld_p1) host_hold <= rd_word;
        end
    end

    assign op_rd_data  = op_vld_p1   ? rd_word : op_hold;
    assign host_rvalid = host_vld_p1;
    assign host_rdata  = host_vld_p1 ? rd_word : host_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= C_IDLE;
            sweep_cnt      <= '0;
            clr_busy       <= 1'b0;
            clr_done       <= 1'b0;
            clr_start_prev <= 1'b0;
        end else begin
            clr_start_prev <= clr_start;
            clr_done       <= 1'b0;
            case (state)
                C_IDLE: begin
                    if (clr_start & ~clr_start_prev) begin
                        state     <= C_SWEEP;
                        sweep_cnt <= '0;
                        clr_busy  <= 1'b1;
                    end
                end
                C_SWEEP: begin
                    if (!op_wr_en) begin
                        sweep_cnt <= sweep_next;
                        if (sweep_next[ADDR_WIDTH]) begin
                            state    <= C_DONE;
                            clr_busy <= 1'b0;
                            clr_done <= 1'b1;
                        end
                    end
                end
                C_DONE:  state <= C_IDLE;
                default: state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Directed self-checking bench for matrix_mem_responder (honours MATRIX_MEM_RD_BYPASS_EN).
module tb_matrix_mem_responder;

    localparam int EW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_rd_en = 1'b0;
    logic [AW-1:0] op_rd_addr = '0;
    logic [EW-1:0] op_rd_data;
    logic          op_wr_en = 1'b0;
    logic [AW-1:0] op_wr_addr = '0;
    logic [EW-1:0] op_wr_data = '0;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [EW-1:0] host_wdata = '0;
    logic          host_gnt;
    logic          host_rvalid;
    logic [EW-1:0] host_rdata;
    logic          clr_start = 1'b0;
    logic          clr_busy;
    logic          clr_done;

    int checks = 0;
    int failures = 0;

    matrix_mem_responder #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_rd_en    (op_rd_en),
        .op_rd_addr  (op_rd_addr),
        .op_rd_data  (op_rd_data),
        .op_wr_en    (op_wr_en),
        .op_wr_addr  (op_wr_addr),
        .op_wr_data  (op_wr_data),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .clr_start   (clr_start),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_write(input logic [AW-1:0] a, input logic [EW-1:0] d);
        op_wr_en = 1'b1; op_wr_addr = a; op_wr_data = d;
        tick();
        op_wr_en = 1'b0;
    endtask

    task automatic op_read(input logic [AW-1:0] a, output logic [EW-1:0] d);
        op_rd_en = 1'b1; op_rd_addr = a;
        tick();
        op_rd_en = 1'b0;
        d = op_rd_data;
    endtask

    task automatic wait_gnt(input string tag);
        int n = 0;
        #1;
        while (!host_gnt && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check_eq(tag, 32'(host_gnt), 32'd1);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [EW-1:0] d);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        wait_gnt("host_wr_gnt_timeout");
        tick();
        host_req = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [EW-1:0] d);
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        wait_gnt("host_rd_gnt_timeout");
        tick();
        host_req = 1'b0;
        check_eq("host_read_rvalid", 32'(host_rvalid), 32'd1);
        d = host_rdata;
    endtask

    logic [EW-1:0] d;
    logic [EW-1:0] exp_new;
    int            busy_cycles;
    int            done_seen;

    initial begin
        // Reset state
        #2;
        check_eq("rst_op_rd_data", 32'(op_rd_data), 32'h0);
        check_eq("rst_host_rdata", 32'(host_rdata), 32'h0);
        check_eq("rst_host_rvalid", 32'(host_rvalid), 32'h0);
        check_eq("rst_clr_busy", 32'(clr_busy), 32'h0);
        check_eq("rst_clr_done", 32'(clr_done), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Op basic
        op_write(12'h010, 16'h00A5);
        op_read(12'h010, d);
        check_eq("op_basic_rd", 32'(d), 32'h00A5);
        repeat (3) tick();
        check_eq("op_basic_hold", 32'(op_rd_data), 32'h00A5);

        // Host read blocked by op read
        op_rd_en = 1'b1; op_rd_addr = 12'h000;
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'h010;
        #1;
        check_eq("host_rd_gnt_blocked", 32'(host_gnt), 32'd0);
        tick();
        check_eq("host_rd_gnt_blocked2", 32'(host_gnt), 32'd0);
        op_rd_en = 1'b0;
        #1;
        check_eq("host_rd_gnt_free", 32'(host_gnt), 32'd1);
        tick();
        host_req = 1'b0;
        check_eq("host_rd_rvalid", 32'(host_rvalid), 32'd1);
        check_eq("host_rd_rdata", 32'(host_rdata), 32'h00A5);
        tick();
        check_eq("host_rd_rvalid_pulse", 32'(host_rvalid), 32'd0);
        check_eq("host_rd_rdata_hold", 32'(host_rdata), 32'h00A5);

        // Host write blocked by op write
        op_wr_en = 1'b1; op_wr_addr = 12'h021; op_wr_data = 16'h0777;
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'h020; host_wdata = 16'h1234;
        #1;
        check_eq("host_wr_gnt_blocked", 32'(host_gnt), 32'd0);
        tick();
        check_eq("host_wr_gnt_blocked2", 32'(host_gnt), 32'd0);
        op_wr_en = 1'b0;
        #1;
        check_eq("host_wr_gnt_free", 32'(host_gnt), 32'd1);
        tick();
        host_req = 1'b0;
        check_eq("host_wr_no_rvalid", 32'(host_rvalid), 32'd0);
        op_read(12'h020, d);
        check_eq("host_wr_data", 32'(d), 32'h1234);
        op_read(12'h021, d);
        check_eq("op_wr_during_host", 32'(d), 32'h0777);

        // Same-address op read + op write
        op_write(12'h030, 16'h0001);
`ifdef MATRIX_MEM_RD_BYPASS_EN
        exp_new = 16'h0002;
`else
        exp_new = 16'h0001;
`endif
        op_wr_en = 1'b1; op_wr_addr = 12'h030; op_wr_data = 16'h0002;
        op_rd_en = 1'b1; op_rd_addr = 12'h030;
        tick();
        op_wr_en = 1'b0; op_rd_en = 1'b0;
        check_eq("collide_op_rd", 32'(op_rd_data), 32'(exp_new));
        op_read(12'h030, d);
        check_eq("collide_op_after", 32'(d), 32'h0002);

        // Same-address host read + op write
`ifdef MATRIX_MEM_RD_BYPASS_EN
        exp_new = 16'h0003;
`else
        exp_new = 16'h0002;
`endif
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'h030;
        op_wr_en = 1'b1; op_wr_addr = 12'h030; op_wr_data = 16'h0003;
        #1;
        check_eq("collide_host_gnt", 32'(host_gnt), 32'd1);
        tick();
        host_req = 1'b0; op_wr_en = 1'b0;
        check_eq("collide_host_rdata", 32'(host_rdata), 32'(exp_new));

        // Clear sweep with a 5-cycle op-write stall
        op_write(12'h000, 16'hFFFF);
        op_write(12'h7FF, 16'hFFFF);
        op_write(12'hFFF, 16'hFFFF);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check_eq("sweep_busy_start", 32'(clr_busy), 32'd1);
        busy_cycles = 0;
        done_seen = 0;
        while (clr_busy && busy_cycles < 5000) begin
            if (busy_cycles == 10) begin
                host_req = 1'b1; host_we = 1'b1; host_addr = 12'h040; host_wdata = 16'h9999;
                #1;
                check_eq("sweep_host_wr_blocked", 32'(host_gnt), 32'd0);
                host_we = 1'b0;
                #1;
                check_eq("sweep_host_rd_allowed", 32'(host_gnt), 32'd1);
            end
            op_wr_en   = (busy_cycles >= 2000 && busy_cycles < 2005);
            op_wr_addr = 12'h001;
            op_wr_data = 16'h5555;
            if (clr_done) done_seen++;
            tick();
            host_req = 1'b0;
            op_wr_en = 1'b0;
            busy_cycles++;
        end
        check_eq("sweep_busy_cycles", 32'(busy_cycles), 32'd4101);
        check_eq("sweep_no_early_done", 32'(done_seen), 32'd0);
        check_eq("sweep_done_pulse", 32'(clr_done), 32'd1);
        tick();
        check_eq("sweep_done_cleared", 32'(clr_done), 32'd0);
        op_read(12'h000, d);
        check_eq("sweep_clr_000", 32'(d), 32'h0);
        op_read(12'h7FF, d);
        check_eq("sweep_clr_7ff", 32'(d), 32'h0);
        op_read(12'hFFF, d);
        check_eq("sweep_clr_fff", 32'(d), 32'h0);
        op_read(12'h001, d);
        check_eq("sweep_swept_wr_kept", 32'(d), 32'h5555);

        // Reset mid-sweep
        host_write(12'h050, 16'hBEEF);
        host_write(12'h020, 16'hBEEF);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (64) tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(clr_busy), 32'd0);
        check_eq("midrst_done", 32'(clr_done), 32'd0);
        check_eq("midrst_op_rd_data", 32'(op_rd_data), 32'h0);
        check_eq("midrst_host_rdata", 32'(host_rdata), 32'h0);
        check_eq("midrst_host_rvalid", 32'(host_rvalid), 32'h0);
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (clr_done || clr_busy) done_seen++;
            tick();
        end
        check_eq("midrst_no_done", 32'(done_seen), 32'd0);
        op_read(12'h050, d);
        check_eq("midrst_unswept_kept", 32'(d), 32'hBEEF);
        op_read(12'h020, d);
        check_eq("midrst_swept_zero", 32'(d), 32'h0);

        // Integration: scalar multiply by 3 of a 2x3 matrix [1..6]
        for (int i = 0; i < 6; i++) host_write(AW'(i), EW'(i + 1));
        for (int i = 0; i < 6; i++) begin
            op_read(AW'(i), d);
            tick();
            op_write(AW'(12'h100 + i), EW'(op_rd_data * 3));
        end
        begin
            logic [EW-1:0] exp_tbl [6] = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd15, 16'd18};
            for (int i = 0; i < 6; i++) begin
                host_read(AW'(12'h100 + i), d);
                check_eq($sformatf("smul_res_%0d", i), 32'(d), 32'(exp_tbl[i]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
